// File: rtl/tdes_pass_sequencer_pkg.sv
// tdes_pkg: shared state enum, mode/pass constants, block width and per-pass mode helper
package tdes_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;
  localparam logic MODE_ENC = 1'b1;
  localparam logic MODE_DEC = 1'b0;
  localparam logic [1:0] LAST_PASS = 2'd2;
  localparam int DES_BLOCK_W = 64;
  function automatic logic pass_mode(input logic ed, input logic [1:0] p);
    return (p == 2'd1) ? ((ed == MODE_ENC) ? MODE_DEC : MODE_ENC) : ed;
  endfunction
endpackage

// File: rtl/tdes_pass_sequencer_if.sv
// tdes_pass_sequencer_if: controller request (start/ed_sel/abort/keys/data_in), DES core handshake (core_*), results (data_out/done/busy/timeout_err)
interface tdes_pass_sequencer_if;
  import tdes_pkg::*;
  logic start;
  logic ed_sel;
  logic abort;
  logic [DES_BLOCK_W-1:0] key1;
  logic [DES_BLOCK_W-1:0] key2;
  logic [DES_BLOCK_W-1:0] data_in;
  logic core_start;
  logic core_mode;
  logic [DES_BLOCK_W-1:0] core_key;
  logic [DES_BLOCK_W-1:0] core_data;
  logic core_done;
  logic [DES_BLOCK_W-1:0] core_result;
  logic [DES_BLOCK_W-1:0] data_out;
  logic done;
  logic busy;
  logic timeout_err;
  modport master(
    output start, ed_sel, abort, key1, key2, data_in, core_done, core_result,
    input core_start, core_mode, core_key, core_data, data_out, done, busy, timeout_err
  );
  modport slave(
    input start, ed_sel, abort, key1, key2, data_in, core_done, core_result,
    output core_start, core_mode, core_key, core_data, data_out, done, busy, timeout_err
  );
endinterface

// File: rtl/tdes_pass_sequencer_timeout_counter.sv
// tdes_timeout_counter: per-pass watchdog; clr restarts, en counts a waiting cycle, expired flags the last allowed cycle (never with TIMEOUT_CYCLES=0)
module tdes_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int TO_W = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  if (TIMEOUT_CYCLES == 0) begin : g_off
    assign expired = 1'b0;
  end else begin : g_on
    logic [TO_W-1:0] cnt;
    always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en) cnt <= cnt + TO_W'(1);
    assign expired = en && cnt == TO_W'(TIMEOUT_CYCLES - 1);
  end
endmodule

// File: rtl/tdes_pass_sequencer.sv
// tdes_pass_sequencer: runs E-D-E / D-E-D over one DES core; ports clk, rst and bus (slave: start/ed_sel/abort/keys/data_in in, core_* handshake, data_out/done/busy/timeout_err out)
module tdes_pass_sequencer
  import tdes_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic clk,
  input logic rst,
  tdes_pass_sequencer_if.slave bus
);
  state_t state;
  logic [1:0] pass;
  logic ed;
  logic [DES_BLOCK_W-1:0] k1;
  logic [DES_BLOCK_W-1:0] k2;
  logic expired;
  tdes_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk(clk),
    .rst(rst),
    .clr(state == ISSUE),
    .en(state == WAIT && !bus.core_done),
    .expired(expired)
  );
  // core_data doubles as the work register: it holds the block for the pass in flight and the recirculated result
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      pass <= '0;
      ed <= 1'b0;
      k1 <= '0;
      k2 <= '0;
      bus.core_start <= 1'b0;
      bus.core_mode <= 1'b0;
      bus.core_key <= '0;
      bus.core_data <= '0;
      bus.data_out <= '0;
      bus.done <= 1'b0;
      bus.busy <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.core_start <= 1'b0;
      bus.done <= 1'b0;
      bus.timeout_err <= 1'b0;
      if (bus.abort && state != IDLE) begin
        state <= IDLE;
        bus.busy <= 1'b0;
      end else
        case (state)
          IDLE:
            if (bus.start) begin
              ed <= bus.ed_sel;
              k1 <= bus.key1;
              k2 <= bus.key2;
              pass <= '0;
              bus.core_data <= bus.data_in;
              bus.core_key <= bus.key1;
              bus.core_mode <= bus.ed_sel;
              bus.core_start <= 1'b1;
              bus.busy <= 1'b1;
              state <= ISSUE;
            end
          ISSUE: state <= WAIT;
          WAIT:
            if (bus.core_done) begin
              bus.core_data <= bus.core_result;
              if (pass == LAST_PASS) state <= FINISH;
              else begin
                pass <= pass + 2'd1;
                bus.core_key <= pass == 2'd0 ? k2 : k1;
                bus.core_mode <= pass_mode(ed, pass + 2'd1);
                bus.core_start <= 1'b1;
                state <= ISSUE;
              end
            end else if (expired) begin
              bus.timeout_err <= 1'b1;
              bus.busy <= 1'b0;
              state <= IDLE;
            end
          FINISH: begin
            bus.data_out <= bus.core_data;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state <= IDLE;
          end
        endcase
    end
endmodule

// File: tb/tb_tdes_pass_sequencer.sv
// tb_tdes_pass_sequencer: bench for tdes_pass_sequencer with a +1 core of latency 4
module tb_tdes_pass_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  tdes_pass_sequencer_if bus();
  tdes_pass_sequencer #(.TIMEOUT_CYCLES(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic ed;
    logic [63:0] k1;
    logic [63:0] k2;
    logic [63:0] din;
    logic [63:0] exp;
    bit disturb;
  } vec_t;
  vec_t vecs[8];
  int total = 0;
  int bad = 0;
  int ndone = 0;
  int nto = 0;
  int dly = 0;
  bit core_en = 1'b1;
  bit inj = 1'b0;
  logic [63:0] pend = '0;
  logic [63:0] last_out = '0;
  logic [63:0] key_q[$];
  logic mode_q[$];
  // three passes through a core that adds one: the whole operation adds three, whatever the keys and modes
  function automatic logic [63:0] ref_out(input logic [63:0] d);
    return d + 64'd3;
  endfunction
  always @(negedge clk) begin
    bus.core_done = 1'b0;
    if (inj) begin
      bus.core_done = 1'b1;
      bus.core_result = 64'hDEAD_BEEF_DEAD_BEEF;
      inj = 1'b0;
    end
    if (dly > 0) begin
      dly--;
      if (dly == 0) begin
        bus.core_done = 1'b1;
        bus.core_result = pend;
      end
    end
    if (bus.core_start && core_en) begin
      pend = bus.core_data + 64'd1;
      dly = 4;
    end
    if (bus.core_start) begin
      key_q.push_back(bus.core_key);
      mode_q.push_back(bus.core_mode);
    end
    if (bus.done) ndone++;
    if (bus.timeout_err) nto++;
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic run_op(input vec_t v, input string nm);
    int lat;
    int d0;
    bit busy_ok;
    logic [63:0] ek[3];
    logic em[3];
    ek = '{v.k1, v.k2, v.k1};
    em = '{v.ed, ~v.ed, v.ed};
    busy_ok = 1'b1;
    key_q.delete();
    mode_q.delete();
    d0 = ndone;
    @(negedge clk);
    bus.start = 1'b1;
    bus.ed_sel = v.ed;
    bus.key1 = v.k1;
    bus.key2 = v.k2;
    bus.data_in = v.din;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 60) begin
      if (!bus.busy) busy_ok = 1'b0;
      if (v.disturb && lat == 7) begin
        bus.start = 1'b1;
        bus.key1 = ~v.k1;
        bus.key2 = '0;
        bus.data_in = {$urandom, $urandom};
        bus.ed_sel = ~v.ed;
      end else bus.start = 1'b0;
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    chk({nm, " latency"}, 64'(lat), 64'd17);
    chk({nm, " data_out"}, bus.data_out, v.exp);
    chk({nm, " busy"}, 64'(busy_ok), 64'd1);
    chk({nm, " passes"}, 64'(key_q.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      if (i < key_q.size()) begin
        chk({nm, " key"}, key_q[i], ek[i]);
        chk({nm, " mode"}, 64'(mode_q[i]), 64'(em[i]));
      end
    repeat (20) @(negedge clk);
    chk({nm, " done count"}, 64'(ndone - d0), 64'd1);
    chk({nm, " data_out held"}, bus.data_out, v.exp);
    last_out = v.exp;
  endtask
  initial begin
    int d0;
    int t0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.ed_sel = 1'b0;
    bus.key1 = '0;
    bus.key2 = '0;
    bus.data_in = '0;
    vecs[0] = '{1'b1, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 64'h0, ref_out(64'h0), 1'b0};
    vecs[1] = '{1'b0, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 64'hFFFF_FFFF_FFFF_FFFD, ref_out(64'hFFFF_FFFF_FFFF_FFFD), 1'b0};
    vecs[2] = '{1'b1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h5555_0000_AAAA_0000, ref_out(64'h5555_0000_AAAA_0000), 1'b1};
    for (int i = 3; i < 8; i++) begin
      vecs[i].ed = 1'($urandom);
      vecs[i].k1 = {$urandom, $urandom};
      vecs[i].k2 = {$urandom, $urandom};
      vecs[i].din = {$urandom, $urandom};
      vecs[i].exp = ref_out(vecs[i].din);
      vecs[i].disturb = 1'($urandom);
    end
    repeat (2) @(negedge clk);
    chk("reset flags", 64'({bus.busy, bus.done, bus.core_start, bus.timeout_err, bus.core_mode}), 64'd0);
    chk("reset data_out", bus.data_out, 64'd0);
    chk("reset core_key", bus.core_key, 64'd0);
    chk("reset core_data", bus.core_data, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) run_op(vecs[i], $sformatf("vec%0d", i));
    d0 = ndone;
    @(negedge clk);
    bus.start = 1'b1;
    bus.ed_sel = 1'b1;
    bus.data_in = 64'h5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.abort = 1'b1;
    #1 chk("abort with core_done", 64'(bus.core_done), 64'd1);
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort busy", 64'(bus.busy), 64'd0);
    repeat (30) @(negedge clk);
    chk("abort no done", 64'(ndone - d0), 64'd0);
    chk("abort data_out", bus.data_out, last_out);
    run_op('{1'b1, 64'hA5A5_A5A5_A5A5_A5A5, 64'h5A5A_5A5A_5A5A_5A5A, 64'h1000, ref_out(64'h1000), 1'b0}, "after abort");
    core_en = 1'b0;
    d0 = ndone;
    t0 = nto;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    chk("timeout early", 64'({bus.timeout_err, bus.busy}), 64'b01);
    @(negedge clk);
    chk("timeout pulse", 64'({bus.timeout_err, bus.busy}), 64'b10);
    @(negedge clk);
    chk("timeout single", 64'(bus.timeout_err), 64'd0);
    repeat (3) @(negedge clk);
    inj = 1'b1;
    repeat (10) @(negedge clk);
    chk("timeout count", 64'(nto - t0), 64'd1);
    chk("late done ignored", 64'({ndone - d0, 31'(bus.busy)}), 64'd0);
    chk("timeout data_out", bus.data_out, last_out);
    core_en = 1'b1;
    run_op('{1'b0, 64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0, 64'h77, ref_out(64'h77), 1'b0}, "after timeout");
    @(negedge clk);
    bus.start = 1'b1;
    bus.ed_sel = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("async rst flags", 64'({bus.busy, bus.done, bus.core_start, bus.timeout_err, bus.core_mode}), 64'd0);
    chk("async rst data_out", bus.data_out, 64'd0);
    chk("async rst core_key", bus.core_key, 64'd0);
    chk("async rst core_data", bus.core_data, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    run_op(vecs[0], "after reset");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
